// File: rtl/emu_sequencer_if.sv
// Signal bundle between the emulation sequencer (slave) and the command controller,
// stimulus source and filter pair (master side).
interface emu_sequencer_if #(
  parameter int DATA_W = 24
);
  logic                     soft_rstn;
  logic                     start;
  logic                     stim_valid;
  logic                     emu_en;
  logic                     flt_clr;
  logic                     out_valid;
  logic signed [DATA_W-1:0] ref_data;
  logic signed [DATA_W-1:0] dut_data;
  logic                     busy;
  logic [63:0]              mse_data;
  logic                     mse_valid;
  logic                     timeout_err;

  modport master (
    output soft_rstn, start, stim_valid, out_valid, ref_data, dut_data,
    input  emu_en, flt_clr, busy, mse_data, mse_valid, timeout_err
  );

  modport slave (
    input  soft_rstn, start, stim_valid, out_valid, ref_data, dut_data,
    output emu_en, flt_clr, busy, mse_data, mse_valid, timeout_err
  );
endinterface

// File: rtl/emu_sequencer.sv
// Runs one word-length emulation pass: clears the filter pair, streams the stimulus and
// accumulates the saturating sum of squared differences between the two filter outputs.
module emu_sequencer #(
  parameter int NUM_SAMPLES = 1024,
  parameter int WARMUP      = 32,
  parameter int DATA_W      = 24,
  parameter int FLUSH_CYC   = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic           clk,
  input  logic           rst,
  emu_sequencer_if.slave bus
);
  localparam int TOTAL = WARMUP + NUM_SAMPLES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SQ_W  = 2 * DATA_W + 2;
  localparam int SUM_W = ((SQ_W > 64) ? SQ_W : 64) + 1;

  localparam logic [CNT_W-1:0] WARMUP_C     = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] TOTAL_C      = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST_C = FL_W'(FLUSH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST_C    = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [SQ_W-1:0]  sq_q, sq_d;
  logic             sq_vld_q, sq_vld_d;
  logic             sq_last_q, sq_last_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mse_q, mse_d;
  logic             mse_vld_q, mse_vld_d;
  logic             to_err_q, to_err_d;

  logic signed [DATA_W:0] ref_x, dut_x, diff;
  logic signed [SQ_W-1:0] diff_x;
  logic [SQ_W-1:0]        sq_full;
  logic [SUM_W-1:0]       sum;
  logic [63:0]            acc_sat;
  logic                   streaming;
  logic                   pair_live;
  logic                   emu_en;

  // One extra bit keeps the difference of two full-scale opposite-sign samples exact.
  assign ref_x   = {bus.ref_data[DATA_W-1], bus.ref_data};
  assign dut_x   = {bus.dut_data[DATA_W-1], bus.dut_data};
  assign diff    = ref_x - dut_x;
  assign diff_x  = SQ_W'(diff);
  assign sq_full = $unsigned(diff_x * diff_x);

  assign sum     = SUM_W'(acc_q) + SUM_W'(sq_q);
  assign acc_sat = (|sum[SUM_W-1:64]) ? {64{1'b1}} : sum[63:0];

  assign streaming = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign pair_live = bus.out_valid && streaming;
  assign emu_en    = (state_q == S_RUN) && bus.stim_valid && bus.soft_rstn;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    issue_d   = issue_q;
    out_cnt_d = out_cnt_q;
    idle_d    = idle_q;
    sq_d      = sq_q;
    sq_vld_d  = 1'b0;
    sq_last_d = 1'b0;
    acc_d     = sq_vld_q ? acc_sat : acc_q;
    mse_d     = mse_q;
    mse_vld_d = 1'b0;
    to_err_d  = to_err_q;

    // Output pairs are counted as soon as streaming starts, not only once issuing is over.
    if (pair_live) begin
      if (out_cnt_q != TOTAL_C) out_cnt_d = out_cnt_q + CNT_W'(1);
      if ((out_cnt_q >= WARMUP_C) && (out_cnt_q < TOTAL_C)) begin
        sq_d      = sq_full;
        sq_vld_d  = 1'b1;
        sq_last_d = (out_cnt_q == LAST_C);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_FLUSH;
          flush_d   = '0;
          issue_d   = '0;
          out_cnt_d = '0;
          acc_d     = '0;
          to_err_d  = 1'b0;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST_C) state_d = S_RUN;
        else                         flush_d = flush_q + FL_W'(1);
      end
      S_RUN: begin
        if (emu_en) begin
          issue_d = issue_q + CNT_W'(1);
          if (issue_q == LAST_C) begin
            state_d = S_DRAIN;
            idle_d  = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_valid) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST_C) begin
          state_d   = S_DONE;
          to_err_d  = 1'b1;
          mse_d     = acc_d;
          mse_vld_d = 1'b1;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Final square lands in the accumulator on this edge, so publish the updated sum.
    if (sq_vld_q && sq_last_q && streaming) begin
      state_d   = S_DONE;
      mse_d     = acc_sat;
      mse_vld_d = 1'b1;
      to_err_d  = to_err_q;
    end

    if (!bus.soft_rstn) begin
      state_d   = S_IDLE;
      flush_d   = '0;
      issue_d   = '0;
      out_cnt_d = '0;
      idle_d    = '0;
      sq_vld_d  = 1'b0;
      sq_last_d = 1'b0;
      acc_d     = '0;
      mse_d     = '0;
      mse_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      flush_q   <= '0;
      issue_q   <= '0;
      out_cnt_q <= '0;
      idle_q    <= '0;
      sq_q      <= '0;
      sq_vld_q  <= 1'b0;
      sq_last_q <= 1'b0;
      acc_q     <= '0;
      mse_q     <= '0;
      mse_vld_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      issue_q   <= issue_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= idle_d;
      sq_q      <= sq_d;
      sq_vld_q  <= sq_vld_d;
      sq_last_q <= sq_last_d;
      acc_q     <= acc_d;
      mse_q     <= mse_d;
      mse_vld_q <= mse_vld_d;
      to_err_q  <= to_err_d;
    end
  end

  assign bus.emu_en      = emu_en;
  assign bus.flt_clr     = (state_q == S_FLUSH) && bus.soft_rstn;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.mse_data    = mse_q;
  assign bus.mse_valid   = mse_vld_q;
  assign bus.timeout_err = to_err_q;
endmodule
